// File: rtl/fft_iter_pkg.sv
// Shared definitions for the in-place radix-2 FFT address generator:
// the sequencer state encoding and the default geometry (32 points).
package fft_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } fft_state_t;

    localparam int DEF_LAYERS      = 5;
    localparam int DEF_BUTTERFLYES = 16;
    localparam int DEF_LAY_WL      = 3;
    localparam int DEF_BUTT_WL     = 4;

endpackage

// File: rtl/fft_bit_insert.sv
// Inserts one bit at a variable position: bits below pos keep their place,
// bits at or above pos move up by one.
module fft_bit_insert #(
    parameter int IN_W  = 4,
    parameter int POS_W = 3
) (
    input  logic [IN_W-1:0]  src,
    input  logic [POS_W-1:0] pos,
    input  logic             bit_val,
    output logic [IN_W:0]    result
);

    logic [IN_W:0] wide;
    logic [IN_W:0] one_w;
    logic [IN_W:0] low_mask;

    always_comb begin
        wide     = {1'b0, src};
        one_w    = {{IN_W{1'b0}}, 1'b1};
        low_mask = (one_w << pos) - one_w;
        result   = ((wide & ~low_mask) << 1) | (wide & low_mask)
                 | ({{IN_W{1'b0}}, bit_val} << pos);
    end

endmodule

// File: rtl/fft_iter_addr_gen.sv
// Butterfly/layer sequencer producing in-place RAM and twiddle addresses for
// an iterative radix-2 FFT. Define FFT_ADDR_ERR_EN to enable the sticky overrun flag ERR.
module fft_iter_addr_gen
    import fft_iter_pkg::*;
#(
    parameter int LAYERS      = DEF_LAYERS,
    parameter int BUTTERFLYES = DEF_BUTTERFLYES,
    parameter int LayWL       = DEF_LAY_WL,
    parameter int ButtWL      = DEF_BUTT_WL
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              ADDR_RST,
    input  logic              ADDR_EN,
    output logic [LAYERS-1:0] ADDR_A,
    output logic [LAYERS-1:0] ADDR_B,
    output logic [ButtWL-1:0] ADDR_W,
    output logic              LAST_LAY,
    output logic              DONE,
    output logic              ERR
);

    localparam logic [ButtWL-1:0] LAST_B = ButtWL'(BUTTERFLYES - 1);
    localparam logic [LayWL-1:0]  LAST_L = LayWL'(LAYERS - 1);

    fft_state_t        state_q, state_d;
    logic [ButtWL-1:0] b_q, b_d;
    logic [LayWL-1:0]  l_q, l_d;
    logic              done_q, done_d;
    logic              overrun;

    // State and counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            b_q     <= '0;
            l_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            l_q     <= l_d;
            done_q  <= done_d;
        end
    end

    // Next-state and counter stepping; ADDR_RST wins over ADDR_EN
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        l_d     = l_q;
        done_d  = 1'b0;
        overrun = 1'b0;
        if (EN) begin
            if (ADDR_RST) begin
                state_d = RUN;
                b_d     = '0;
                l_d     = '0;
            end else if (ADDR_EN) begin
                if (state_q == RUN) begin
                    if (b_q != LAST_B) begin
                        b_d = b_q + ButtWL'(1);
                    end else if (l_q != LAST_L) begin
                        b_d = '0;
                        l_d = l_q + LayWL'(1);
                    end else begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end else begin
                    overrun = 1'b1;
                end
            end
        end
    end

`ifdef FFT_ADDR_ERR_EN
    logic err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (overrun) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`else
    logic unused_overrun;
    assign unused_overrun = overrun;
    assign ERR            = 1'b0;
`endif

    logic [LayWL-1:0]  pos;
    logic [ButtWL-1:0] low_mask;
    logic [ButtWL:0]   one_w;

    // Output decode, purely from the registered counters
    always_comb begin
        pos      = LAST_L - l_q;
        one_w    = {{ButtWL{1'b0}}, 1'b1};
        low_mask = ButtWL'((one_w << pos) - one_w);
        ADDR_W   = (b_q & low_mask) << l_q;
        LAST_LAY = ((state_q == RUN) || (state_q == FIN)) && (l_q == LAST_L);
        DONE     = done_q;
    end

    fft_bit_insert #(.IN_W(ButtWL), .POS_W(LayWL)) u_ins_a (
        .src    (b_q),
        .pos    (pos),
        .bit_val(1'b0),
        .result (ADDR_A)
    );

    fft_bit_insert #(.IN_W(ButtWL), .POS_W(LayWL)) u_ins_b (
        .src    (b_q),
        .pos    (pos),
        .bit_val(1'b1),
        .result (ADDR_B)
    );

endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// Testbench for fft_iter_addr_gen: directed milestones plus randomized control
// traffic against a step-count reference model.
module tb_fft_iter_addr_gen;

    localparam int L   = 5;
    localparam int NB  = 16;
    localparam int TOT = L * NB;
`ifdef FFT_ADDR_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       addr_rst = 1'b0;
    logic       addr_en = 1'b0;
    logic [4:0] addr_a, addr_b;
    logic [3:0] addr_w;
    logic       last_lay, done, err;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 run, 2 fin; s = butterflies stepped in this pass
    int  m_st = 0;
    int  m_s = 0;
    bit  m_done = 1'b0;
    bit  m_err = 1'b0;

    always #5 clk = ~clk;

    fft_iter_addr_gen #(.LAYERS(5), .BUTTERFLYES(16), .LayWL(3), .ButtWL(4)) dut (
        .CLK     (clk),
        .RST     (rst),
        .EN      (en),
        .ADDR_RST(addr_rst),
        .ADDR_EN (addr_en),
        .ADDR_A  (addr_a),
        .ADDR_B  (addr_b),
        .ADDR_W  (addr_w),
        .LAST_LAY(last_lay),
        .DONE    (done),
        .ERR     (err)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit ar, input bit ae);
        if (r) begin
            m_st = 0; m_s = 0; m_done = 1'b0; m_err = 1'b0;
        end else if (!e) begin
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (ar) begin
                m_st = 1; m_s = 0;
            end else if (ae) begin
                if (m_st == 1) begin
                    if (m_s == TOT - 1) begin
                        m_st = 2; m_done = 1'b1;
                    end else begin
                        m_s++;
                    end
                end else if (ERR_ON) begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic check_model();
        int b, l, pos, lo, a_exp;
        b     = m_s % NB;
        l     = m_s / NB;
        pos   = L - 1 - l;
        lo    = b % (1 << pos);
        a_exp = ((b >> pos) << (pos + 1)) + lo;
        check("addr_a", addr_a, a_exp);
        check("addr_b", addr_b, a_exp + (1 << pos));
        check("addr_w", addr_w, (lo << l) % NB);
        check("last_lay", last_lay, (m_st != 0 && l == L - 1) ? 1 : 0);
        check("done", done, m_done);
        check("err", err, m_err);
    endtask

    task automatic cycle(input bit r, input bit e, input bit ar, input bit ae);
        rst = r; en = e; addr_rst = ar; addr_en = ae;
        @(posedge clk);
        model_edge(r, e, ar, ae);
        #1;
        check_model();
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        #2;
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_a", addr_a, 0);
        check("rst_b", addr_b, 16);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("start_b", addr_b, 16);
        pulses(5);
        check("p5_a", addr_a, 5);
        check("p5_b", addr_b, 21);
        check("p5_w", addr_w, 5);
        pulses(16);
        check("p21_b", addr_b, 13);
        check("p21_w", addr_w, 10);
        pulses(48);
        check("p69_a", addr_a, 10);
        check("p69_b", addr_b, 11);
        check("p69_last", last_lay, 1);
        pulses(10);
        check("p79_done", done, 0);
        pulses(1);
        check("p80_done", done, 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("done_once", done, 0);
        pulses(1);
        check("overrun_err", err, ERR_ON);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("restart_a", addr_a, 0);
        check("err_sticky", err, ERR_ON);
        pulses(40);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("midrst_b", addr_b, 16);
        check("midrst_err", err, 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        pulses(7);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("hold_a", addr_a, 7);
        check("hold_b", addr_b, 23);

        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_iter_addr_gen.md
FFT_ITER_ADDR_GEN -- requirements
Module: fft_iter_addr_gen

Interface
REQ-001 Parameter LAYERS, default 5, number of radix-2 stages; N = 2^LAYERS points.
REQ-002 Parameter BUTTERFLYES, default 16, butterflies per layer; SHALL equal 2^(LAYERS-1).
REQ-003 Parameter LayWL, default 3, layer counter width; SHALL satisfy 2^LayWL > LAYERS.
REQ-004 Parameter ButtWL, default 4, butterfly counter width; SHALL equal LAYERS-1.
REQ-005 CLK  in  1  clock; all state updates on rising edge.
REQ-006 RST  in  1  reset; synchronous, active-high.
REQ-007 EN  in  1  clock enable; when low, all registers hold.
REQ-008 ADDR_RST  in  1  restart address sequence at layer 0, butterfly 0.
REQ-009 ADDR_EN  in  1  advance to next butterfly (one step per cycle high).
REQ-010 ADDR_A  out  LAYERS  upper-operand RAM address of current butterfly.
REQ-011 ADDR_B  out  LAYERS  lower-operand RAM address of current butterfly.
REQ-012 ADDR_W  out  ButtWL  twiddle ROM index of current butterfly.
REQ-013 LAST_LAY  out  1  high while current layer = LAYERS-1.
REQ-014 DONE  out  1  one-cycle pulse after final butterfly of final layer is stepped.
REQ-015 ERR  out  1  sticky sequencing error flag.

Function
REQ-016 State machine states IDLE, RUN, FIN; registered butterfly counter b (ButtWL) and layer counter l (LayWL).
REQ-017 ADDR_RST (EN high) from any state: next state RUN, b=0, l=0; priority over ADDR_EN.
REQ-018 RUN, ADDR_EN, b<BUTTERFLYES-1: b increments.
REQ-019 RUN, ADDR_EN, b=BUTTERFLYES-1, l<LAYERS-1: b wraps to 0, l increments.
REQ-020 RUN, ADDR_EN, b=BUTTERFLYES-1, l=LAYERS-1: next state FIN, counters hold, DONE high for exactly the following cycle.
REQ-021 FIN and IDLE: counters hold; ADDR_EN without ADDR_RST is an overrun (see REQ-029).
REQ-022 Address decode combinational from registered counters, so outputs reflect a step in the cycle after ADDR_EN: pos = LAYERS-1-l; ADDR_A = b with a 0 bit inserted at bit pos (bits below pos unchanged, bits at/above pos shifted up one); ADDR_B = ADDR_A with bit pos set.
REQ-023 ADDR_W = (b mod 2^pos) shifted left by l, truncated to ButtWL bits; l=LAYERS-1 gives ADDR_W=0.
REQ-024 ADDR_A/B/W stable while ADDR_EN low; read and write of one butterfly use identical addresses (in-place).
REQ-025 LAST_LAY = (state=RUN or FIN) and l=LAYERS-1.
REQ-026 EN low: no state change, DONE not emitted, outputs hold.

Reset
REQ-027 RST high at a clock edge: state IDLE, b=0, l=0, DONE=0, ERR=0, LAST_LAY=0, ADDR_A=0, ADDR_B=2^(LAYERS-1), ADDR_W=0; RST overrides EN, ADDR_RST and any in-progress sequence.
REQ-028 ERR cleared only by RST; ADDR_RST does not clear ERR.

Configuration
REQ-029 Macro FFT_ADDR_ERR_EN defined: ADDR_EN in IDLE or FIN (without ADDR_RST) sets ERR the next cycle. Undefined: no check logic, ERR constant 0; all other behaviour identical.

Structure
REQ-030 Shared package fft_iter_pkg holds state encodings (IDLE/RUN/FIN) and default LAYERS/ButtWL/LayWL constants.
REQ-031 One sub-module fft_bit_insert (combinational: insert bit at variable position) instantiated twice (ADDR_A with 0, ADDR_B with 1).

Verification (LAYERS=5)
REQ-032 RST then ADDR_RST -> ADDR_A=0, ADDR_B=16, ADDR_W=0, LAST_LAY=0, DONE=0.
REQ-033 5 ADDR_EN pulses in layer 0 -> ADDR_A=5, ADDR_B=21, ADDR_W=5.
REQ-034 21 pulses (layer 1, b=5) -> ADDR_A=5, ADDR_B=13, ADDR_W=10; 69 pulses (layer 4, b=5) -> ADDR_A=10, ADDR_B=11, ADDR_W=0, LAST_LAY=1.
REQ-035 80 pulses -> DONE high exactly one cycle, state FIN; 81st pulse -> ERR=1 (macro defined) or ERR=0 (undefined); ADDR_RST -> addresses back to 0/16, ERR still 1.
REQ-036 RST at pulse 40 -> all outputs at REQ-027 values next cycle; EN low with ADDR_EN high for 3 cycles -> counters and outputs unchanged.
